ad9228_stream_packer: RTL and testbench

Drains one AD9228 channel's sample FIFO, on the FIFO read-clock side, and turns it into framed 32-bit AXI-Stream words for the control-board readout path. Each word packs two 12-bit samples with a channel ID and a frame sequence tag. Frames are fixed-length and are started only while `enable` is high. The block sits directly downstream of the per-channel ADC read stage: it drives that stage's `fifo_rd_en` and consumes `fifo_dout` / `fifo_not_empty`.

---
 rtl/ad9228_stream_packer.sv | 172 +++++++++++++++++
 tb/tb_ad9228_stream_packer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9228_stream_packer.sv
// AD9228 per-channel stream packer.
// Pops 12-bit samples from the channel read FIFO and packs pairs of them into
// framed 32-bit AXI-Stream words: {CH_ID, s1, seq, s0}. Each frame has a fixed
// length, and a new frame starts only while `enable` is high in IDLE.
module ad9228_stream_packer #(
  parameter int         SAMPLES_PER_FRAME = 1024,
  parameter logic [3:0] CH_ID             = 4'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        fifo_not_empty,
  input  logic [11:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [15:0] frame_count
);

  // SAMPLES_PER_FRAME must be even and at least 2; frames carry WORDS words.
  localparam int DATA_W = 12;
  localparam int WORDS  = SAMPLES_PER_FRAME / 2;
  localparam int ICNT_W = $clog2(SAMPLES_PER_FRAME + 1);
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ICNT_W-1:0] ISSUE_MAX = ICNT_W'(SAMPLES_PER_FRAME);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [ICNT_W-1:0]  issued;
  logic [15:0]        frame_cnt;

  // Capture stage: vld_p1 marks that fifo_dout carries the sample read last cycle.
  logic               vld_p1;
  logic               half_p1;
  logic [DATA_W-1:0]  s0_p1;
  logic [WCNT_W-1:0]  word_cnt;

  // Two-entry output buffer, entries hold {tlast, tdata}; buf0 is the head.
  logic [32:0]        buf0;
  logic [32:0]        buf1;
  logic [1:0]         out_count;

  logic [2:0]         credit;
  logic               rd_en;
  logic               push;
  logic               pop;
  logic               pop_last;
  logic [32:0]        push_entry;

  function automatic logic [31:0] pack_word(input logic [DATA_W-1:0] s1,
                                            input logic [3:0]        seq,
                                            input logic [DATA_W-1:0] s0);
    return {CH_ID, s1, seq, s0};
  endfunction

  // Reads still in flight or already captured must always fit in the buffer,
  // counting two half-words per buffered word; a pop this cycle is not credited.
  assign credit     = {out_count, 1'b0} + {2'b00, half_p1} + {2'b00, vld_p1};
  assign rd_en      = (state == RUN) && fifo_not_empty && (issued < ISSUE_MAX) &&
                      (credit < 3'd4);
  assign push       = vld_p1 && half_p1;
  assign pop        = (out_count != 2'd0) && m_axis_tready;
  assign pop_last   = pop && buf0[32];
  assign push_entry = {(word_cnt == WORD_LAST), pack_word(fifo_dout, frame_cnt[3:0], s0_p1)};

  assign fifo_rd_en    = rd_en;
  assign m_axis_tvalid = (out_count != 2'd0);
  assign m_axis_tdata  = buf0[31:0];
  assign m_axis_tlast  = buf0[32] && (out_count != 2'd0);
  assign busy          = (state != IDLE);
  assign frame_count   = frame_cnt;

  // Frame sequencing: start on enable, issue a frame's worth of reads, then
  // wait for the tlast handshake before returning to IDLE and bumping the frame tag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      issued    <= '0;
      frame_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= RUN;
            issued <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            issued <= issued + ICNT_W'(1);
          end
          if (issued == ISSUE_MAX) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_last) begin
            state     <= IDLE;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: capture returning FIFO data, pair samples, count words ----
  // Track the read pipeline and pair samples into words.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      half_p1  <= 1'b0;
      s0_p1    <= '0;
      word_cnt <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (vld_p1) begin
        if (!half_p1) begin
          s0_p1   <= fifo_dout;
          half_p1 <= 1'b1;
        end else begin
          half_p1  <= 1'b0;
          word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + WCNT_W'(1);
        end
      end
    end
  end

  // ---- stage p2: output buffer feeding the AXI-Stream master ----
  // Two-entry FIFO with simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf0      <= '0;
      buf1      <= '0;
      out_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (out_count == 2'd0) begin
            buf0 <= push_entry;
          end else begin
            buf1 <= push_entry;
          end
          out_count <= out_count + 2'd1;
        end
        2'b01: begin
          buf0      <= buf1;
          out_count <= out_count - 2'd1;
        end
        2'b11: begin
          if (out_count == 2'd1) begin
            buf0 <= push_entry;
          end else begin
            buf0 <= buf1;
            buf1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9228_stream_packer.sv
// Directed bench for ad9228_stream_packer with SAMPLES_PER_FRAME=8, CH_ID=0.
module tb_ad9228_stream_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_not_empty;
  logic [11:0] fifo_dout = 12'd0;
  logic        fifo_rd_en;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  // upstream FIFO model (std mode, one-cycle read latency)
  logic [11:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  // AXI-Stream sink controls and capture
  bit          bp_mode = 1'b0;
  bit          tready_set = 1'b0;
  logic [31:0] cap_data [0:255];
  bit          cap_last [0:255];
  int          cap_n = 0;
  int          stab_viol = 0;
  bit          stall_prev = 1'b0;
  bit          rstn_prev = 1'b0;
  logic [31:0] hold_data = 32'd0;
  logic        hold_last = 1'b0;

  ad9228_stream_packer #(.SAMPLES_PER_FRAME(8), .CH_ID(4'd0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .fifo_not_empty (fifo_not_empty),
    .fifo_dout      (fifo_dout),
    .fifo_rd_en     (fifo_rd_en),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  assign fifo_not_empty = (rd_ptr != wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode) m_axis_tready = ($urandom_range(0, 99) < 30);
    else         m_axis_tready = tready_set;
  end

  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready && cap_n < 256) begin
      cap_data[cap_n] = m_axis_tdata;
      cap_last[cap_n] = m_axis_tlast;
      cap_n++;
    end
    if (stall_prev && rstn_prev) begin
      if (!m_axis_tvalid || m_axis_tdata !== hold_data || m_axis_tlast !== hold_last)
        stab_viol++;
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    hold_data  = m_axis_tdata;
    hold_last  = m_axis_tlast;
    rstn_prev  = rstn;
  end

  function automatic logic [31:0] exp_word(input logic [11:0] s1, input logic [3:0] seq,
                                           input logic [11:0] s0);
    return {4'h0, s1, seq, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = 12'(first + 12'(i));
      wr_ptr++;
    end
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    tready_set = 1'b0;
    bp_mode    = 1'b0;
    wr_ptr     = rd_ptr;
    rstn       = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_fc(input logic [15:0] target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (frame_count == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // raise enable until the block leaves IDLE, then drop it
  task automatic start_frame(output bit ok);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %h want 0", frame_count); end
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp [0:7];
    int b;
    bit ok;
    exp = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007,
            32'h000A_1009, 32'h000C_100B, 32'h000E_100D, 32'h0010_100F};
    do_reset();
    b = cap_n;
    preload(12'h001, 16);
    tready_set = 1'b1;
    enable = 1'b1;
    wait_fc(16'd1, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_frame1_done got %b want 1", ok); end
    for (int i = 0; i < 10 && !busy; i++) tick();
    enable = 1'b0;
    wait_fc(16'd2, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_frame2_done got %b want 1", ok); end
    repeat (4) tick();
    checks++; if (cap_n - b !== 8) begin errors++; $display("FAIL basic_word_count got %0d want 8", cap_n - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[b+i] !== exp[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, cap_data[b+i], exp[i]); end
      checks++;
      if (cap_last[b+i] !== (i % 4 == 3)) begin errors++; $display("FAIL basic_tlast%0d got %b want %b", i, cap_last[b+i], (i % 4 == 3)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL basic_frame_count got %h want 2", frame_count); end
  endtask

  task automatic test_backpressure();
    int b, v0, r0;
    bit ok;
    do_reset();
    b = cap_n; v0 = stab_viol; r0 = rd_ptr;
    preload(12'hA00, 8);
    bp_mode = 1'b1;
    start_frame(ok);
    wait_fc(16'd1, 600, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_frame_done got %b want 1", ok); end
    bp_mode = 1'b0;
    repeat (3) tick();
    checks++; if (cap_n - b !== 4) begin errors++; $display("FAIL bp_word_count got %0d want 4", cap_n - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_word(12'(12'hA01 + 12'(2*i)), 4'd0, 12'(12'hA00 + 12'(2*i)))) begin
        errors++;
        $display("FAIL bp_word%0d got %h want %h", i, cap_data[b+i],
                 exp_word(12'(12'hA01 + 12'(2*i)), 4'd0, 12'(12'hA00 + 12'(2*i))));
      end
    end
    checks++; if (cap_last[b+3] !== 1'b1) begin errors++; $display("FAIL bp_tlast got %b want 1", cap_last[b+3]); end
    checks++; if (stab_viol - v0 !== 0) begin errors++; $display("FAIL bp_stall_stability got %0d violations want 0", stab_viol - v0); end
    checks++; if (rd_ptr - r0 !== 8) begin errors++; $display("FAIL bp_reads got %0d want 8", rd_ptr - r0); end
  endtask

  task automatic test_starvation();
    int b, r0, hi;
    bit ok;
    do_reset();
    b = cap_n; r0 = rd_ptr;
    preload(12'h301, 3);
    tready_set = 1'b1;
    start_frame(ok);
    for (int i = 0; i < 20 && (rd_ptr - r0) < 3; i++) tick();
    checks++; if (rd_ptr - r0 !== 3) begin errors++; $display("FAIL starve_first_reads got %0d want 3", rd_ptr - r0); end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd_en) hi++;
      tick();
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL starve_rd_en_in_gap got %0d cycles want 0", hi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL starve_busy got %b want 1", busy); end
    preload(12'h304, 5);
    wait_fc(16'd1, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL starve_frame_done got %b want 1", ok); end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_data[b+i] !== exp_word(12'(12'h302 + 12'(2*i)), 4'd0, 12'(12'h301 + 12'(2*i)))) begin
        errors++;
        $display("FAIL starve_word%0d got %h want %h", i, cap_data[b+i],
                 exp_word(12'(12'h302 + 12'(2*i)), 4'd0, 12'(12'h301 + 12'(2*i))));
      end
    end
    checks++; if (cap_last[b+3] !== 1'b1) begin errors++; $display("FAIL starve_tlast got %b want 1", cap_last[b+3]); end
  endtask

  task automatic test_enable_drop();
    int b, r0, hi;
    bit ok;
    do_reset();
    b = cap_n; r0 = rd_ptr;
    preload(12'h400, 10);
    tready_set = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 50 && cap_n == b; i++) tick();
    enable = 1'b0;
    checks++; if (cap_n - b < 1) begin errors++; $display("FAIL drop_first_word got %0d words want >=1", cap_n - b); end
    wait_fc(16'd1, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_frame_done got %b want 1", ok); end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_rd_en) hi++;
    end
    checks++; if (cap_n - b !== 4) begin errors++; $display("FAIL drop_word_count got %0d want 4", cap_n - b); end
    checks++; if (cap_last[b+3] !== 1'b1) begin errors++; $display("FAIL drop_tlast got %b want 1", cap_last[b+3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL drop_idle_reads got %0d want 0", hi); end
    checks++; if (rd_ptr - r0 !== 8) begin errors++; $display("FAIL drop_reads got %0d want 8", rd_ptr - r0); end
  endtask

  task automatic test_reset_mid_frame();
    int b, r0, k;
    bit ok;
    logic [31:0] want;
    do_reset();
    r0 = rd_ptr;
    preload(12'h501, 12);
    tready_set = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 10 && !fifo_rd_en; i++) tick();
    tick();
    tick();
    rstn = 1'b0;
    enable = 1'b0;
    tick();
    rstn = 1'b1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL rstmid_tdata got %h want 0", m_axis_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rstmid_frame_count got %h want 0", frame_count); end
    tick();
    k = rd_ptr - r0;
    b = cap_n;
    tready_set = 1'b1;
    start_frame(ok);
    wait_fc(16'd1, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_frame_done got %b want 1", ok); end
    repeat (3) tick();
    want = exp_word(12'(12'h502 + 12'(k)), 4'd0, 12'(12'h501 + 12'(k)));
    checks++; if (cap_data[b] !== want) begin errors++; $display("FAIL rstmid_first_word got %h want %h", cap_data[b], want); end
    checks++; if (cap_n - b !== 4) begin errors++; $display("FAIL rstmid_word_count got %0d want 4", cap_n - b); end
  endtask

  task automatic test_wrap();
    logic [15:0] fc_exp [0:3];
    logic [3:0]  seq_exp [0:3];
    int b;
    bit ok;
    logic [11:0] base;
    fc_exp  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    seq_exp = '{4'hD, 4'hE, 4'hF, 4'h0};
    do_reset();
    force dut.frame_cnt = 16'hFFFD;
    tick();
    release dut.frame_cnt;
    tick();
    checks++; if (frame_count !== 16'hFFFD) begin errors++; $display("FAIL wrap_preset got %h want fffd", frame_count); end
    tready_set = 1'b1;
    for (int f = 0; f < 4; f++) begin
      base = 12'(12'h600 + 12'(8*f));
      b = cap_n;
      preload(base, 8);
      start_frame(ok);
      wait_fc(fc_exp[f], 200, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_frame%0d_count got %h want %h", f, frame_count, fc_exp[f]); end
      repeat (2) tick();
      checks++;
      if (cap_data[b] !== exp_word(12'(base + 12'd1), seq_exp[f], base)) begin
        errors++;
        $display("FAIL wrap_frame%0d_word got %h want %h", f, cap_data[b], exp_word(12'(base + 12'd1), seq_exp[f], base));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_starvation();
    test_enable_drop();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
